serial_word_assembler: RTL
==========================

Name: serial_word_assembler

Overview:
- Downstream companion of the team's right-shift register: consumes its serial output (q[0], LSB first, one bit per enabled clock) and rebuilds DW-bit parallel words.
- Completed words are presented on a valid/ready output port with a one-word holding register.
- Words that arrive while the holding register is blocked raise a sticky overflow flag.

Parameters:
- DW, 4, word width in bits; must be >= 2.
- CW, $clog2(DW), width of the bit counter. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- sync_rst  input  1  synchronous reset, active-high; sampled on the clk rising edge.
- bit_in  input  1  serial data bit, LSB of the word first.
- bit_vld  input  1  qualifies bit_in for the current cycle (ties to the shifter's en).
- word_out  output  DW  assembled word; stable while word_vld=1 and word_rdy=0.
- word_vld  output  1  holding register contains an unconsumed word.
- word_rdy  input  1  consumer accepts word_out when word_vld & word_rdy are both 1 at the edge.
- busy  output  1  1 while a partial word is being collected (bit count != 0).
- bit_cnt  output  CW  number of bits collected so far in the current word, 0..DW-1.
- ovf  output  1  sticky overflow flag: a completed word was dropped.
- clr_ovf  input  1  clears ovf on the next edge.

Behaviour:
- Reset: sync_rst=1 at an edge sets the shift register, bit_cnt, word_out, word_vld and ovf to 0. Reset overrides every other input in that cycle. Reset mid-word discards the partial word, with no ovf.
- Shift: on an edge with bit_vld=1, sr <= {bit_in, sr[DW-1:1]} and bit_cnt increments. After DW bits, sr[0] holds the first bit received. bit_vld=0 holds sr and bit_cnt.
- FSM with 2 states, bits indicated by bit_cnt:
  - IDLE (bit_cnt=0): leaves to COLLECT on bit_vld.
  - COLLECT: stays while bit_cnt < DW-1.
  - The edge with bit_vld=1 and bit_cnt=DW-1 is the completion edge: bit_cnt wraps to 0 and the state returns to IDLE.
- Completion: the completed word {bit_in, sr[DW-1:1]} is written directly to word_out on the completion edge. word_vld=1 from the following cycle, so latency is 1 clock from the last bit's edge.
- Handshake: word_vld clears on an edge with word_vld & word_rdy, unless a completion happens on the same edge.
- Completion and acceptance on the same edge: the new word loads and word_vld stays 1. Back-to-back words at full rate have no bubble.
- Completion while word_vld=1 and word_rdy=0: the new word is dropped, word_out keeps the old word, and ovf is set. The shift register still restarts at bit_cnt=0.
- ovf: sticky until clr_ovf or reset. If clr_ovf and a new overflow occur on the same edge, the set wins (ovf=1).
- busy = (bit_cnt != 0); combinational from registered state.
- No combinational path from word_rdy to word_vld or word_out.

Decomposition:
- Shared package: the FSM state encoding (ST_IDLE, ST_COLLECT) and the default DW constant, reused by the serializer-side blocks.
- One natural sub-module, sawr_hold_reg: the word_out/word_vld holding register with valid/ready accept, load and drop logic, plus ovf generation.
- The shift register and counter remain in the top module.

Test Plan (DW=4, word_rdy=1 unless stated):
- Reset: assert sync_rst for 2 cycles with bit_vld=1 -> word_out=0, word_vld=0, bit_cnt=0, ovf=0, busy=0 throughout.
- Basic word: bits 1,0,1,1 on 4 consecutive edges -> word_out=4'hD with word_vld=1 exactly one cycle after the 4th edge; word_vld=0 the next cycle.
- Gapped input: bits 0,1 / bit_vld=0 for 3 cycles / bits 1,0 -> bit_cnt holds at 2 during the gap; word_out=4'h6.
- Back-to-back: 8 continuous bits forming 4'hA then 4'h5 -> word_vld stays 1 for two cycles showing A then 5; ovf=0.
- Overflow: word_rdy=0; send 4'h3 then 4'hC -> word_out stays 4'h3 and ovf=1. Then word_rdy=1 -> word_vld drops. Then clr_ovf=1 for one cycle -> ovf=0.
- Mid-word reset: send 2 bits, then sync_rst for 1 cycle, then bits 1,1,1,1 -> word_out=4'hF and no partial-word contamination.

Source files
------------

// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word path: FSM state encoding and default word width.
package serial_word_assembler_pkg;

    localparam int DEFAULT_DW = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } sawr_state_t;

endpackage

// File: rtl/sawr_hold_reg.sv
// One-word output holding register with valid/ready accept, load/drop decision and sticky overflow.
module sawr_hold_reg
    import serial_word_assembler_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          rdy_i,
    input  logic          clr_ovf_i,
    output logic [DW-1:0] word_o,
    output logic          vld_o,
    output logic          ovf_o
);

    logic [DW-1:0] word_q, word_d;
    logic          vld_q, vld_d;
    logic          ovf_q, ovf_d;
    logic          blocked;
    logic          drop;

    always_comb begin
        word_d  = word_q;
        vld_d   = vld_q;
        ovf_d   = ovf_q;
        blocked = vld_q & ~rdy_i;
        drop    = load_i & blocked;

        if (load_i && !blocked) begin
            word_d = load_data_i;
            vld_d  = 1'b1;
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end

        // A fresh overflow outranks a clear requested on the same edge.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            word_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end

    assign word_o = word_q;
    assign vld_o  = vld_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Rebuilds DW-bit words from an LSB-first serial stream and hands them off through a holding register.
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter  int DW = DEFAULT_DW,
    localparam int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          bit_in,
    input  logic          bit_vld,
    output logic [DW-1:0] word_out,
    output logic          word_vld,
    input  logic          word_rdy,
    output logic          busy,
    output logic [CW-1:0] bit_cnt,
    output logic          ovf,
    input  logic          clr_ovf
);

    sawr_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] sr_q, sr_d;
    logic          complete;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        complete = 1'b0;

        if (bit_vld) begin
            sr_d = {bit_in, sr_q[DW-1:1]};
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COLLECT;
                    cnt_d   = cnt_q + CW'(1);
                end
                ST_COLLECT: begin
                    if (cnt_q == CW'(DW-1)) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    // On the completion edge sr_d already holds the finished word, last bit in the MSB.
    sawr_hold_reg #(
        .DW(DW)
    ) u_hold (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .load_i     (complete),
        .load_data_i(sr_d),
        .rdy_i      (word_rdy),
        .clr_ovf_i  (clr_ovf),
        .word_o     (word_out),
        .vld_o      (word_vld),
        .ovf_o      (ovf)
    );

    assign bit_cnt = cnt_q;
    assign busy    = (cnt_q != '0);

endmodule
